// File: rtl/interleaver_pkg.sv
// Shared types and sizing helpers for the block interleaver sequencer.
package interleaver_pkg;

    localparam int unsigned DEF_ROWS = 4;
    localparam int unsigned DEF_COLS = 4;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    function automatic int unsigned calc_depth(input int unsigned rows, input int unsigned cols);
        return rows * cols;
    endfunction

    // Index width for a range of n entries, never narrower than one bit.
    function automatic int unsigned calc_aw(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/interleaver_ctrl_mod_counter.sv
// Modulo-MOD up counter with enable, synchronous reset and a wrap flag.
module mod_counter
    import interleaver_pkg::*;
#(
    parameter  int unsigned MOD = 4,
    localparam int unsigned W   = calc_aw(MOD)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         wrap_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Wrap flag is qualified by enable: it marks the step that returns to zero.
    assign wrap_o = en_i && (cnt_q == W'(MOD - 1));
    assign cnt_o  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = wrap_o ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/interleaver_ctrl.sv
// Block interleaver sequencer: row-major one-hot writes into a register bank,
// then column-major read-mux selection with a valid/ready handshake.
module interleaver_ctrl
    import interleaver_pkg::*;
#(
    parameter  int unsigned ROWS  = DEF_ROWS,
    parameter  int unsigned COLS  = DEF_COLS,
    localparam int unsigned DEPTH = calc_depth(ROWS, COLS),
    localparam int unsigned AW    = calc_aw(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [DEPTH-1:0] reg_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [AW-1:0]    rd_sel,
    output logic             out_last,
    output logic             busy
);

    localparam int unsigned RW = calc_aw(ROWS);
    localparam int unsigned CW = calc_aw(COLS);

    state_e          state_q, state_d;
    logic [AW-1:0]   rd_sel_q, rd_sel_d;
    logic            out_valid_q, out_valid_d;
    logic            out_last_q, out_last_d;
    logic            busy_q, busy_d;

    logic [AW-1:0]   wr_cnt;
    logic [RW-1:0]   rd_row;
    logic [CW-1:0]   rd_col;
    logic            wr_wrap, row_wrap, col_wrap;
    logic            accept, xfer;

    // Handshakes; in_ready is masked during reset so nothing is accepted then.
    assign in_ready = (state_q == FILL) && !reset;
    assign accept   = in_ready && in_valid;
    assign xfer     = out_valid_q && out_ready;
    assign reg_en   = accept ? (DEPTH'(1) << wr_cnt) : '0;

    assign out_valid = out_valid_q;
    assign rd_sel    = rd_sel_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;

    mod_counter #(.MOD(DEPTH)) u_wr_cnt (
        .clk    (clk),
        .reset  (reset),
        .en_i   (accept),
        .cnt_o  (wr_cnt),
        .wrap_o (wr_wrap)
    );

    mod_counter #(.MOD(ROWS)) u_rd_row (
        .clk    (clk),
        .reset  (reset),
        .en_i   (xfer),
        .cnt_o  (rd_row),
        .wrap_o (row_wrap)
    );

    mod_counter #(.MOD(COLS)) u_rd_col (
        .clk    (clk),
        .reset  (reset),
        .en_i   (row_wrap),
        .cnt_o  (rd_col),
        .wrap_o (col_wrap)
    );

    // rd_sel tracks rd_row*COLS + rd_col incrementally: +COLS per row step,
    // restart at the next column on a row wrap.
    always_comb begin
        state_d     = state_q;
        rd_sel_d    = rd_sel_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;

        case (state_q)
            FILL: begin
                if (wr_wrap) begin
                    state_d     = DRAIN;
                    out_valid_d = 1'b1;
                    rd_sel_d    = '0;
                    out_last_d  = 1'b0;
                end
            end
            DRAIN: begin
                if (xfer) begin
                    // Next position is last when stepping from row ROWS-2 in the last column.
                    out_last_d = (rd_col == CW'(COLS - 1)) && (rd_row == RW'(ROWS - 2));
                    if (!row_wrap) begin
                        rd_sel_d = rd_sel_q + AW'(COLS);
                    end else if (col_wrap) begin
                        state_d     = FILL;
                        out_valid_d = 1'b0;
                        rd_sel_d    = '0;
                    end else begin
                        rd_sel_d = AW'(rd_col) + AW'(1);
                    end
                end
            end
        endcase

        busy_d = (state_d == DRAIN) || ((state_q == FILL) && ((wr_cnt != '0) || accept));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FILL;
            rd_sel_q    <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_sel_q    <= rd_sel_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
        end
    end

endmodule

// File: tb/tb_interleaver_ctrl.sv
// Bench for interleaver_ctrl: a 4x4 instance and a 2x3 instance, each with a
// behavioural register bank so delivered bytes can be scoreboarded.
module tb_interleaver_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last, a_busy;
    logic [15:0] a_reg_en;
    logic [3:0]  a_rd_sel;
    logic [7:0]  a_din;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_busy;
    logic [5:0]  b_reg_en;
    logic [2:0]  b_rd_sel;
    logic [7:0]  b_din;

    interleaver_ctrl #(.ROWS(4), .COLS(4)) dut_a (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .reg_en    (a_reg_en),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .rd_sel    (a_rd_sel),
        .out_last  (a_out_last),
        .busy      (a_busy)
    );

    interleaver_ctrl #(.ROWS(2), .COLS(3)) dut_b (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .reg_en    (b_reg_en),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .rd_sel    (b_rd_sel),
        .out_last  (b_out_last),
        .busy      (b_busy)
    );

    // Behavioural banks written through the controller's enables.
    logic [7:0] bank_a [16];
    logic [7:0] bank_b [8];

    always @(posedge clk) begin
        for (int k = 0; k < 16; k++) if (a_reg_en[k]) bank_a[k] <= a_din;
        for (int k = 0; k < 6; k++)  if (b_reg_en[k]) bank_b[k] <= b_din;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reset one cycle mid-block, then check the restart accepts into register 0.
    task automatic reset_a(input string tag);
        @(negedge clk);
        reset = 1'b1; a_in_valid = 1'b1; a_out_ready = 1'b1;
        #1;
        chk({tag, "_in_ready_during"}, 32'(a_in_ready), 32'(0));
        chk({tag, "_reg_en_during"}, 32'(a_reg_en), 32'(0));
        @(negedge clk);
        reset = 1'b0; a_in_valid = 1'b1; a_out_ready = 1'b0; a_din = 8'hAA;
        #1;
        chk({tag, "_out_valid"}, 32'(a_out_valid), 32'(0));
        chk({tag, "_rd_sel"}, 32'(a_rd_sel), 32'(0));
        chk({tag, "_out_last"}, 32'(a_out_last), 32'(0));
        chk({tag, "_busy"}, 32'(a_busy), 32'(0));
        chk({tag, "_in_ready"}, 32'(a_in_ready), 32'(1));
        chk({tag, "_reg_en"}, 32'(a_reg_en), 32'(1));
    endtask

    typedef struct {
        logic        in_valid;
        logic        out_ready;
        logic [7:0]  din;
        logic        exp_in_ready;
        logic [15:0] exp_reg_en;
        logic        exp_out_valid;
        logic [3:0]  exp_rd_sel;
        logic        exp_out_last;
        logic        exp_busy;
    } vec_t;

    vec_t vecs [33];

    initial begin
        logic [7:0] wr [16];
        logic [7:0] exp_q [$];
        logic [7:0] e;
        logic [3:0] prev_sel;
        logic       prev_last, prev_stall;
        int         k, budget, blk, p, j;

        // Block 1 of the 4x4 instance: 16 fills, 16 drains at full rate, one idle.
        for (int i = 0; i < 16; i++) begin
            vecs[i] = '{1'b1, 1'b0, 8'(i), 1'b1, 16'(32'h1 << i), 1'b0, 4'd0, 1'b0, (i != 0)};
        end
        for (int i = 0; i < 16; i++) begin
            vecs[16 + i] = '{1'b0, 1'b1, 8'h00, 1'b0, 16'h0, 1'b1,
                             4'(((i % 4) * 4) + (i / 4)), (i == 15), 1'b1};
        end
        vecs[32] = '{1'b0, 1'b0, 8'h00, 1'b1, 16'h0, 1'b0, 4'd0, 1'b0, 1'b0};

        reset = 1'b1;
        a_in_valid = 1'b1; a_out_ready = 1'b0; a_din = 8'h00;
        b_in_valid = 1'b0; b_out_ready = 1'b0; b_din = 8'h00;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_ready", 32'(a_in_ready), 32'(0));
        chk("rst_reg_en", 32'(a_reg_en), 32'(0));
        chk("rst_out_valid", 32'(a_out_valid), 32'(0));
        chk("rst_rd_sel", 32'(a_rd_sel), 32'(0));
        chk("rst_out_last", 32'(a_out_last), 32'(0));
        chk("rst_busy", 32'(a_busy), 32'(0));
        @(negedge clk);
        reset = 1'b0; a_in_valid = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(a_in_ready), 32'(1));

        for (int i = 0; i < 33; i++) begin
            @(negedge clk);
            a_in_valid = vecs[i].in_valid; a_out_ready = vecs[i].out_ready; a_din = vecs[i].din;
            #1;
            chk($sformatf("v%0d_in_ready", i), 32'(a_in_ready), 32'(vecs[i].exp_in_ready));
            chk($sformatf("v%0d_reg_en", i), 32'(a_reg_en), 32'(vecs[i].exp_reg_en));
            chk($sformatf("v%0d_out_valid", i), 32'(a_out_valid), 32'(vecs[i].exp_out_valid));
            chk($sformatf("v%0d_rd_sel", i), 32'(a_rd_sel), 32'(vecs[i].exp_rd_sel));
            chk($sformatf("v%0d_out_last", i), 32'(a_out_last), 32'(vecs[i].exp_out_last));
            chk($sformatf("v%0d_busy", i), 32'(a_busy), 32'(vecs[i].exp_busy));
        end

        // Block 2: bursty fill with distinct bytes, stalled drain with in_valid held high.
        k = 0; budget = 0;
        while (k < 16 && budget < 300) begin
            @(negedge clk);
            a_in_valid = 1'($urandom_range(0, 1));
            a_out_ready = 1'($urandom_range(0, 1));
            a_din = {4'(k), 4'($urandom_range(0, 15))};
            #1;
            chk("fill_in_ready", 32'(a_in_ready), 32'(1));
            chk("fill_reg_en", 32'(a_reg_en), a_in_valid ? (32'h1 << k) : 32'h0);
            chk("fill_out_valid", 32'(a_out_valid), 32'(0));
            if (a_in_valid) begin
                wr[k] = a_din;
                k++;
            end
            budget++;
        end
        if (k < 16) chk("fill_timeout", 32'(k), 32'(16));
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) exp_q.push_back(wr[r * 4 + c]);

        budget = 0; prev_stall = 1'b0; prev_sel = '0; prev_last = 1'b0;
        while (exp_q.size() > 0 && budget < 400) begin
            @(negedge clk);
            a_in_valid = 1'b1;
            a_out_ready = ($urandom_range(0, 2) != 0);
            a_din = 8'hEE;
            #1;
            chk("drain_out_valid", 32'(a_out_valid), 32'(1));
            chk("drain_in_ready", 32'(a_in_ready), 32'(0));
            chk("drain_reg_en", 32'(a_reg_en), 32'(0));
            if (prev_stall) begin
                chk("stall_rd_sel", 32'(a_rd_sel), 32'(prev_sel));
                chk("stall_out_last", 32'(a_out_last), 32'(prev_last));
            end
            if (a_out_ready) begin
                e = exp_q.pop_front();
                chk("drain_data", 32'(bank_a[a_rd_sel]), 32'(e));
                chk("drain_out_last", 32'(a_out_last), 32'(exp_q.size() == 0));
            end
            prev_stall = !a_out_ready; prev_sel = a_rd_sel; prev_last = a_out_last;
            budget++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'(0));

        // Back-to-back: accept into register 0 right after the last transfer.
        @(negedge clk);
        a_in_valid = 1'b1; a_out_ready = 1'b0; a_din = 8'h00;
        #1;
        chk("b2b_in_ready", 32'(a_in_ready), 32'(1));
        chk("b2b_reg_en", 32'(a_reg_en), 32'(1));
        chk("b2b_out_valid", 32'(a_out_valid), 32'(0));

        // Six more writes (seven total), then reset mid-fill.
        for (int i = 1; i < 7; i++) begin
            @(negedge clk);
            a_in_valid = 1'b1; a_din = 8'(i);
            #1;
            chk("part_reg_en", 32'(a_reg_en), 32'h1 << i);
        end
        reset_a("rst_fill");

        // Complete the block that reset_a started, read five, reset mid-drain.
        for (int i = 1; i < 16; i++) begin
            @(negedge clk);
            a_in_valid = 1'b1; a_din = 8'(i);
            #1;
            chk("refill_reg_en", 32'(a_reg_en), 32'h1 << i);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a_in_valid = 1'b0; a_out_ready = 1'b1;
            #1;
            chk("part_drain_valid", 32'(a_out_valid), 32'(1));
            chk("part_drain_sel", 32'(a_rd_sel), 32'(((i % 4) * 4) + (i / 4)));
        end
        reset_a("rst_drain");
        @(negedge clk);
        a_in_valid = 1'b0; a_out_ready = 1'b0;

        // 2x3 instance: five back-to-back blocks at full rate on both sides.
        exp_q.delete();
        for (int t = 0; t < 60; t++) begin
            blk = t / 12; p = t % 12;
            @(negedge clk);
            b_in_valid = 1'b1; b_out_ready = 1'b1; b_din = {4'(blk), 4'(p)};
            #1;
            if (p < 6) begin
                chk("b_fill_in_ready", 32'(b_in_ready), 32'(1));
                chk("b_fill_reg_en", 32'(b_reg_en), 32'h1 << p);
                chk("b_fill_out_valid", 32'(b_out_valid), 32'(0));
                if (p == 5) begin
                    for (int c = 0; c < 3; c++)
                        for (int r = 0; r < 2; r++) exp_q.push_back({4'(blk), 4'(r * 3 + c)});
                end
            end else begin
                j = p - 6;
                chk("b_drain_in_ready", 32'(b_in_ready), 32'(0));
                chk("b_drain_reg_en", 32'(b_reg_en), 32'(0));
                chk("b_drain_out_valid", 32'(b_out_valid), 32'(1));
                chk("b_drain_rd_sel", 32'(b_rd_sel), 32'(((j % 2) * 3) + (j / 2)));
                chk("b_drain_out_last", 32'(b_out_last), 32'(j == 5));
                if (exp_q.size() == 0) begin
                    chk("b_sb_empty", 32'(0), 32'(1));
                end else begin
                    e = exp_q.pop_front();
                    chk("b_drain_data", 32'(bank_b[b_rd_sel]), 32'(e));
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/interleaver_ctrl.md
Name: interleaver_ctrl

Overview:
- Sequencer for a block interleaver built from a bank of ROWS*COLS 8-bit enable-gated registers.
- Accepts bytes with a valid/ready handshake and writes them into the bank in row-major order using one-hot register enables.
- Once the bank is full, drives the external read mux select in column-major order with a valid/ready handshake, then returns to fill.
- Controls only; data never passes through this block (write data is broadcast to the bank, read data comes from the external mux).

Parameters:
- ROWS, 4, interleaver rows; must be >= 2.
- COLS, 4, interleaver columns; must be >= 2.
- DEPTH, ROWS*COLS, derived, number of registers in the bank; not to be overridden.
- AW, clog2(DEPTH), derived, width of the read select.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream byte present on the bank's shared data_in.
- in_ready  out  1  controller accepts a byte this cycle.
- reg_en  out  DEPTH  one-hot write enable, bit k drives the enable of register k.
- out_valid  out  1  mux output (selected by rd_sel) is valid.
- out_ready  in  1  downstream consumes the current byte.
- rd_sel  out  AW  register index selected by the read mux.
- out_last  out  1  current output is the final byte of the block.
- busy  out  1  high in DRAIN, or in FILL with wr_cnt != 0.

Behaviour:
- Synchronous, active-high reset applies to all state. Reset values:
  - state = FILL, wr_cnt = 0, rd_row = 0, rd_col = 0.
  - rd_sel = 0, out_valid = 0, out_last = 0, busy = 0, reg_en = 0.
  - in_ready is forced to 0 while reset is high and is 1 in the first cycle after reset.
- State FILL:
  - in_ready = 1, out_valid = 0.
  - reg_en = onehot(wr_cnt) when in_valid is high, else 0. This is combinational, so register wr_cnt captures data_in on the same edge as the accept (zero latency).
  - On each accept, wr_cnt increments.
  - On the accept with wr_cnt == DEPTH-1: wr_cnt wraps to 0, state -> DRAIN, rd_row = 0, rd_col = 0, rd_sel = 0.
- State DRAIN:
  - in_ready = 0, reg_en = 0, out_valid = 1.
  - First out_valid appears the cycle after the last write (write-to-read latency is 1 cycle).
  - rd_sel is a register equal to rd_row*COLS + rd_col and must be built without a multiplier:
    - Row step: rd_sel += COLS.
    - Column wrap: rd_sel = rd_col + 1.
  - On each out_valid & out_ready:
    - If rd_row < ROWS-1: rd_row++.
    - Else: rd_row = 0 and rd_col++.
  - out_last = 1 when rd_row == ROWS-1 and rd_col == COLS-1.
  - A transfer with out_last = 1 moves state to FILL with all counters and rd_sel at 0. in_ready is 1 in the very next cycle (back-to-back blocks, no idle cycle).
- Stall: with out_ready low, rd_sel, out_valid and out_last hold unchanged for any number of cycles.
- in_valid during DRAIN is ignored: no reg_en, and the byte is not consumed.
- Full/empty: the single-buffer bank is either filling or draining, never both. There is no overflow or underflow path.
- Reset mid-block (FILL or DRAIN): the partial block is discarded and the block restarts at FILL with index 0. Bank contents are not cleared by this block.
- Invariants: reg_en is one-hot or zero at all times; rd_sel < DEPTH at all times.

Decomposition:
- Shared package interleaver_pkg holds:
  - state enum {FILL, DRAIN};
  - default ROWS/COLS constants;
  - DEPTH/AW derivation function.
- One natural sub-module, mod_counter: parameterised MOD, with enable, synchronous reset, wrap flag output. Instantiated for wr_cnt (MOD=DEPTH), rd_row (MOD=ROWS) and rd_col (MOD=COLS).

Test Plan:
- Reset, then stream 0x00..0x0F with in_valid held high -> reg_en walks 0x0001..0x8000, one bit per cycle; DRAIN is entered after 16 accepts; first out_valid is 1 cycle later.
- Drain with out_ready = 1 -> rd_sel sequence 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15; out_last only on 15; in_ready = 1 in the next cycle.
- Random out_ready stalls during drain -> rd_sel/out_valid held while stalled; same 16-entry order delivered; no duplicates or skips.
- in_valid high throughout DRAIN -> reg_en stays 0, in_ready stays 0; the next block starts at reg_en bit 0.
- Reset asserted after 7 writes, and separately after 5 reads -> state FILL, wr_cnt 0, rd_sel 0, out_valid 0; the next accept asserts reg_en bit 0.
- ROWS=2, COLS=3 build -> reg_en walks bits 0..5 in order; rd_sel order 0,3,1,4,2,5; out_last on 5; 5 back-to-back blocks with no idle cycles.
